multicycle_control_fsm: RTL

//  Multi-cycle MIPS control unit: one FSM sequences fetch/decode/execute/memory/writeback per instruction.

---
 rtl/multicycle_control_fsm_pkg.sv | 71 +++++++
 rtl/multicycle_control_fsm_if.sv | 34 +++
 rtl/multicycle_control_fsm_alu_decoder.sv | 32 +++
 rtl/multicycle_control_fsm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit:
//   - instruction opcode and R-type funct field encodings
//   - ALU operation codes (ADD=0 SUB=1 AND=2 OR=3 SLT=4)
//   - alu_src_b and pc_src mux select encodings
//   - the controller state enumeration
//   - is_mem_state(): true for states that wait on mem_ready
//
// Configuration macro: MC_CTRL_JUMP_EN
//   Defined   -> the enumeration contains S_JUMP (j instruction supported).
//   Undefined -> no S_JUMP state exists.
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Primary opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field IR[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes, zero-extended to ALU_OP_W at the point of use
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
`ifdef MC_CTRL_JUMP_EN
    S_JUMP,
`endif
    S_ERROR
  } state_t;

  // States in which the controller is waiting for memory to complete a
  // request; only these states count wait cycles and can time out.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm_if
//   Memory handshake between the multi-cycle controller and the shared
//   instruction/data memory.
//
//   mem_read   controller -> memory  read request
//   mem_write  controller -> memory  write request
//   iord       controller -> memory  address select (0=PC, 1=ALUOut)
//   mem_ready  memory -> controller  current request completes this cycle
//
//   Modports: master = controller, slave = memory side.
// ----------------------------------------------------------------------------
interface multicycle_control_fsm_if;

  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  iord,
    output mem_ready
  );

endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ----------------------------------------------------------------------------
// mc_alu_decoder
//   Combinational R-type funct decoder for the multi-cycle controller.
//
//   funct   in   6         IR[5:0]
//   alu_op  out  ALU_OP_W  ALU operation for the funct (ADD when illegal)
//   legal   out  1         funct is one of add/sub/and/or/slt
// ----------------------------------------------------------------------------
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  always_comb begin
    alu_op = ALU_OP_W'(ALU_ADD);
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
      FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
      FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
      FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
      FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
//   Multi-cycle MIPS control unit. One FSM walks each instruction through
//   fetch / decode / execute / memory / writeback and drives the datapath
//   mux selects and write enables. Memory accesses wait for mem_ready with a
//   bounded wait; unsupported instructions and memory timeouts lock the unit
//   in ERROR until reset.
//
// Parameters
//   ALU_OP_W  width of alu_op (>=3)
//   MAX_WAIT  wait cycles a memory state tolerates before timing out (>=1)
//   CNT_W     width of the retired-instruction counter
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   opcode, funct   instruction register fields
//   mem_bus         memory handshake (master modport: mem_read, mem_write,
//                   iord out; mem_ready in)
//   pc_write, pc_write_cond, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, pc_src, alu_op
//                   datapath controls (all 0 in IDLE and ERROR)
//   instr_count     retired instructions, wraps
//   err_illegal     sticky: unsupported opcode or funct
//   err_timeout     sticky: memory wait exceeded MAX_WAIT
//
// Configuration macro: MC_CTRL_JUMP_EN
//   Defined   -> opcode j decodes to JUMP (pc_write, pc_src=jump target).
//   Undefined -> opcode j is treated as illegal.
// ----------------------------------------------------------------------------
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  multicycle_control_fsm_if.master  mem_bus,
  output logic                      pc_write,
  output logic                      pc_write_cond,
  output logic                      ir_write,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      reg_write,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                pc_src,
  output logic [ALU_OP_W-1:0]       alu_op,
  output logic [CNT_W-1:0]          instr_count,
  output logic                      err_illegal,
  output logic                      err_timeout
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t               state_q;
  state_t               state_d;
  logic [WAIT_W-1:0]    wait_cnt_q;
  logic [WAIT_W-1:0]    wait_cnt_d;
  logic [ALU_OP_W-1:0]  alu_op_hold_q;
  logic [ALU_OP_W-1:0]  dec_alu_op;
  logic                 dec_legal;
  logic                 mem_timeout;
  logic                 retire;
  logic                 set_illegal;
  logic                 set_timeout;

  mc_alu_decoder #(
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_decoder (
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // A ready on the limit cycle still completes the access normally.
  assign mem_timeout = (wait_cnt_q == WAIT_LIMIT) && !mem_bus.mem_ready;

  // Next-state and Moore outputs. Only ir_write/pc_write in FETCH and the
  // MEMWR retire pulse depend on mem_ready.
  always_comb begin
    state_d           = state_q;
    pc_write          = 1'b0;
    pc_write_cond     = 1'b0;
    ir_write          = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    reg_write         = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_RT;
    pc_src            = PCSRC_ALU;
    alu_op            = ALU_OP_W'(ALU_ADD);
    mem_bus.mem_read  = 1'b0;
    mem_bus.mem_write = 1'b0;
    mem_bus.iord      = 1'b0;
    retire            = 1'b0;
    set_illegal       = 1'b0;
    set_timeout       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // PC+4 is computed alongside the instruction read so the PC can be
      // updated in the same cycle the instruction register is loaded.
      S_FETCH: begin
        mem_bus.mem_read = 1'b1;
        alu_src_b        = SRCB_FOUR;
        if (mem_bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (mem_timeout) begin
          set_timeout = 1'b1;
          state_d     = S_ERROR;
        end
      end

      // Branch target is precomputed here while the opcode is examined.
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            set_illegal = 1'b1;
            state_d     = S_ERROR;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_bus.mem_read = 1'b1;
        mem_bus.iord     = 1'b1;
        if (mem_bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (mem_timeout) begin
          set_timeout = 1'b1;
          state_d     = S_ERROR;
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_bus.mem_write = 1'b1;
        mem_bus.iord      = 1'b1;
        if (mem_bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (mem_timeout) begin
          set_timeout = 1'b1;
          state_d     = S_ERROR;
        end
      end

      // An unsupported funct is caught here, one cycle before writeback,
      // so no register write is ever issued for it.
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = dec_alu_op;
        if (dec_legal) begin
          state_d = S_ALUWB;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_ERROR;
        end
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = alu_op_hold_q;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_OP_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end

`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The wait counter only runs while parked in a memory state without
  // ready; any state change or completed access clears it, which also
  // covers re-entering FETCH straight out of MEMWR.
  always_comb begin
    wait_cnt_d = '0;
    if (is_mem_state(state_q) && (state_d == state_q) && !mem_bus.mem_ready) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      alu_op_hold_q <= ALU_OP_W'(ALU_ADD);
      instr_count   <= '0;
      err_illegal   <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      // ALUWB replays the operation chosen in EXEC.
      if (state_q == S_EXEC) begin
        alu_op_hold_q <= dec_alu_op;
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (set_illegal) begin
        err_illegal <= 1'b1;
      end
      if (set_timeout) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule
